// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_seq_pkg
//  Brief   : Opcode encodings and opcode-class helpers shared by alu_seq and
//            its iterative mul/div engine (alu_muldiv).
//  Revision: 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    // Base RV32I operations (single cycle)
    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_XOR   = 2;
    localparam int unsigned OP_OR    = 3;
    localparam int unsigned OP_AND   = 4;
    localparam int unsigned OP_SLL   = 5;
    localparam int unsigned OP_SRL   = 6;
    localparam int unsigned OP_SRA   = 7;
    localparam int unsigned OP_SLT   = 8;
    localparam int unsigned OP_SLTU  = 9;
    // M-extension operations (iterative when enabled)
    localparam int unsigned OP_MUL   = 10;
    localparam int unsigned OP_MULHU = 11;
    localparam int unsigned OP_DIV   = 12;
    localparam int unsigned OP_DIVU  = 13;
    localparam int unsigned OP_REM   = 14;
    localparam int unsigned OP_REMU  = 15;

    function automatic logic is_mul_op(input int unsigned op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(input int unsigned op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    function automatic logic is_rem_op(input int unsigned op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_div_op(input int unsigned op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module  : alu_muldiv
//  Brief   : Iterative one-bit-per-cycle engine. MUL/MULHU use a shift-add
//            over a 2*VAR_WIDTH accumulator; DIV/DIVU/REM/REMU use restoring
//            division on operand magnitudes with sign fix-up applied to the
//            result presented alongside done.
//  Revision: 1.0  initial release
// ============================================================================
module alu_muldiv
    import alu_seq_pkg::*;
#(
    parameter int VAR_WIDTH = 32,
    parameter int OP_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 start,
    input  logic [OP_WIDTH-1:0]  op,
    input  logic [VAR_WIDTH-1:0] a,
    input  logic [VAR_WIDTH-1:0] b,
    output logic                 done,
    output logic [VAR_WIDTH-1:0] result
);

    localparam int CW = $clog2(VAR_WIDTH);

    // Iteration state
    logic                   active_q, active_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*VAR_WIDTH-1:0] acc_q, acc_d;      // MUL: product; DIV: {rem, quot}
    logic [VAR_WIDTH-1:0]   opd_q, opd_d;      // multiplicand or divisor magnitude
    logic                   mul_q, mul_d;
    logic                   hi_q, hi_d;
    logic                   rem_q, rem_d;
    logic                   negq_q, negq_d;
    logic                   negr_q, negr_d;

    // Datapath temporaries
    logic [31:0]            op_int;
    logic                   a_neg, b_neg;
    logic [VAR_WIDTH-1:0]   a_mag, b_mag;
    logic [VAR_WIDTH:0]     mul_sum, shifted, diff;
    logic [2*VAR_WIDTH-1:0] mul_next, div_next, step;
    logic [VAR_WIDTH-1:0]   quo, rmd;

    // Operand preparation, one iteration step, counter control and result fix-up
    always_comb begin
        op_int   = 32'(op);
        a_neg    = is_signed_div_op(op_int) && a[VAR_WIDTH-1];
        b_neg    = is_signed_div_op(op_int) && b[VAR_WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;

        mul_sum  = {1'b0, acc_q[2*VAR_WIDTH-1:VAR_WIDTH]}
                 + (acc_q[0] ? {1'b0, opd_q} : {(VAR_WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[VAR_WIDTH-1:1]};

        shifted  = acc_q[2*VAR_WIDTH-1:VAR_WIDTH-1];
        diff     = shifted - {1'b0, opd_q};
        div_next = diff[VAR_WIDTH] ? {acc_q[2*VAR_WIDTH-2:0], 1'b0}
                                   : {diff[VAR_WIDTH-1:0], acc_q[VAR_WIDTH-2:0], 1'b1};
        step     = mul_q ? mul_next : div_next;

        active_d = active_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        mul_d    = mul_q;
        hi_d     = hi_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;

        if (flush) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (start) begin
            active_d = 1'b1;
            cnt_d    = CW'(VAR_WIDTH - 1);
            mul_d    = is_mul_op(op_int);
            hi_d     = (op_int == OP_MULHU);
            rem_d    = is_rem_op(op_int);
            negq_d   = a_neg ^ b_neg;
            negr_d   = a_neg;
            acc_d    = is_mul_op(op_int) ? {{VAR_WIDTH{1'b0}}, b}
                                         : {{VAR_WIDTH{1'b0}}, a_mag};
            opd_d    = is_mul_op(op_int) ? a : b_mag;
        end else if (active_q) begin
            acc_d = step;
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // Final step is folded into the result so it is ready on the last iteration
        quo  = step[VAR_WIDTH-1:0];
        rmd  = step[2*VAR_WIDTH-1:VAR_WIDTH];
        done = active_q && (cnt_q == '0);
        if (mul_q) begin
            result = hi_q ? rmd : quo;
        end else if (rem_q) begin
            result = negr_q ? -rmd : rmd;
        end else begin
            result = negq_q ? -quo : quo;
        end
    end

    // Iteration state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            mul_q    <= 1'b0;
            hi_q     <= 1'b0;
            rem_q    <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            mul_q    <= mul_d;
            hi_q     <= hi_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
        end
    end

endmodule : alu_muldiv
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module  : alu_seq
//  Brief   : Handshaked multi-cycle execute-stage ALU. Base ops complete in
//            one cycle; MUL/MULHU/DIV/DIVU/REM/REMU run on the iterative
//            alu_muldiv engine when ALU_SEQ_MULDIV_EN is defined, otherwise
//            they return 0 in one cycle.
//  Config  : ALU_SEQ_MULDIV_EN
//  Revision: 1.0  initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int VAR_WIDTH = 32,
    parameter int OP_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_WIDTH-1:0]  opcode,
    input  logic [VAR_WIDTH-1:0] a,
    input  logic [VAR_WIDTH-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [VAR_WIDTH-1:0] out,
    output logic                 busy
);

    localparam int SHW = $clog2(VAR_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [VAR_WIDTH-1:0] out_q, out_d;
    logic                 accept;
    logic [31:0]          op_int;

    function automatic logic [VAR_WIDTH-1:0] base_result(
        input int unsigned          op,
        input logic [VAR_WIDTH-1:0] x,
        input logic [VAR_WIDTH-1:0] y
    );
        logic [SHW-1:0] sh;
        sh = y[SHW-1:0];
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_XOR:  return x ^ y;
            OP_OR:   return x | y;
            OP_AND:  return x & y;
            OP_SLL:  return x << sh;
            OP_SRL:  return x >> sh;
            OP_SRA:  return $unsigned($signed(x) >>> sh);
            OP_SLT:  return {{(VAR_WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: return {{(VAR_WIDTH-1){1'b0}}, (x < y)};
            default: return '0;
        endcase
    endfunction

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [VAR_WIDTH-1:0] MIN_VAL = {1'b1, {(VAR_WIDTH-1){1'b0}}};

    logic                 md_start;
    logic                 md_done;
    logic [VAR_WIDTH-1:0] md_result;

    alu_muldiv #(
        .VAR_WIDTH (VAR_WIDTH),
        .OP_WIDTH  (OP_WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (md_start),
        .op     (opcode),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_result)
    );

    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
`else
    assign busy = 1'b0;
`endif

    assign op_int    = 32'(opcode);
    assign in_ready  = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;

    // Next-state, result capture and engine launch
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
`ifdef ALU_SEQ_MULDIV_EN
        md_start = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    state_d = S_DONE;
                    out_d   = base_result(op_int, a, b);
`ifdef ALU_SEQ_MULDIV_EN
                    if (is_mul_op(op_int)) begin
                        state_d  = S_MUL;
                        out_d    = out_q;
                        md_start = 1'b1;
                    end else if (is_div_op(op_int)) begin
                        if (b == '0) begin
                            out_d = is_rem_op(op_int) ? a : '1;
                        end else if (is_signed_div_op(op_int) && (a == MIN_VAL) && (b == '1)) begin
                            out_d = is_rem_op(op_int) ? '0 : a;
                        end else begin
                            state_d  = S_DIV;
                            out_d    = out_q;
                            md_start = 1'b1;
                        end
                    end
`endif
                end
            end
            default: begin
`ifdef ALU_SEQ_MULDIV_EN
                if (md_done) begin
                    state_d = S_DONE;
                    out_d   = md_result;
                end
`else
                state_d = S_IDLE;
`endif
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
            out_d   = out_q;
        end
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alu_seq
//  Brief   : Self-checking bench for alu_seq (VAR_WIDTH=32): directed vector
//            table, randomized ops against an arithmetic reference model,
//            and hand-written handshake / flush / reset sequences.
//  Config  : ALU_SEQ_MULDIV_EN selects the expected mul/div behaviour
//  Revision: 1.0  initial release
// ============================================================================
module tb_alu_seq;

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, busy;
    logic [4:0]  opcode;
    logic [31:0] a, b, out;

    int n_pass  = 0;
    int n_total = 0;

    alu_seq #(.VAR_WIDTH(32), .OP_WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_on;
        logic [31:0] exp_off;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_vec(input string name, input int op, input logic [31:0] x,
                                    input logic [31:0] y, input logic [31:0] e_on,
                                    input logic [31:0] e_off);
        vec_t v;
        v.name = name; v.op = op; v.a = x; v.b = y; v.exp_on = e_on; v.exp_off = e_off;
        vecs.push_back(v);
    endfunction

    // Reference model: plain arithmetic straight from the operation definitions
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [4:0]  sh;
        logic        ovf;
        sh  = y[4:0];
        p   = {32'd0, x} * {32'd0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        if (op >= 10 && op <= 15 && !MD_EN) return 32'd0;
        case (op)
            0:  return x + y;
            1:  return x - y;
            2:  return x ^ y;
            3:  return x | y;
            4:  return x & y;
            5:  return x << sh;
            6:  return x >> sh;
            7:  return $signed(x) >>> sh;
            8:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            9:  return (x < y) ? 32'd1 : 32'd0;
            10: return p[31:0];
            11: return p[63:32];
            12: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : $signed(x) / $signed(y);
            13: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            14: return (y == 0) ? x : ovf ? 32'd0 : $signed(x) % $signed(y);
            15: return (y == 0) ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    // Cycles from presenting an op to seeing out_valid
    function automatic int ref_lat(input int op, input logic [31:0] x, input logic [31:0] y);
        logic ovf;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        if (!MD_EN) return 1;
        if (op == 10 || op == 11) return 33;
        if (op >= 12 && op <= 15 && y != 0 && !((op == 12 || op == 14) && ovf)) return 33;
        return 1;
    endfunction

    // Issue one op from IDLE, wait for its result, check it, then drain it
    task automatic run_op(input string name, input int op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
        int cyc, busy_cnt, rdy_cnt, lat;
        lat      = ref_lat(op, x, y);
        opcode   = 5'(op);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        opcode   = 5'($urandom);
        a        = $urandom;
        b        = $urandom;
        cyc      = 1;
        busy_cnt = 0;
        rdy_cnt  = 0;
        while (!out_valid && cyc < 200) begin
            if (busy) busy_cnt++;
            if (in_ready) rdy_cnt++;
            step();
            cyc++;
        end
        check({name, ".out"}, out, exp);
        check({name, ".latency"}, cyc, lat);
        check({name, ".busy_cycles"}, busy_cnt, lat - 1);
        check({name, ".ready_while_busy"}, rdy_cnt, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int          cnt, op;
        logic [31:0] x, y;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; a = '0; b = '0;
        step();
        step();
        check("reset.out", out, 0);
        check("reset.out_valid", out_valid, 0);
        check("reset.busy", busy, 0);
        rst = 1'b0;
        step();
        check("reset.in_ready", in_ready, 1);

        // Directed vectors
        add_vec("add_wrap",  0,  32'hFFFF_FFFF, 32'h1,          32'h0,          32'h0);
        add_vec("sra",       7,  32'h8000_0000, 32'h24,         32'hF800_0000,  32'hF800_0000);
        add_vec("sub_wrap",  1,  32'h0,         32'h1,          32'hFFFF_FFFF,  32'hFFFF_FFFF);
        add_vec("sll_mask",  5,  32'h1,         32'h21,         32'h2,          32'h2);
        add_vec("srl_31",    6,  32'h8000_0000, 32'h3F,         32'h1,          32'h1);
        add_vec("slt",       8,  32'hFFFF_FFFF, 32'h1,          32'h1,          32'h1);
        add_vec("sltu",      9,  32'hFFFF_FFFF, 32'h1,          32'h0,          32'h0);
        add_vec("xor",       2,  32'hF0F0,      32'hFF00,       32'h0FF0,       32'h0FF0);
        add_vec("or",        3,  32'hF0F0,      32'hFF00,       32'hFFF0,       32'hFFF0);
        add_vec("and",       4,  32'hF0F0,      32'hFF00,       32'hF000,       32'hF000);
        add_vec("mul_lo",    10, 32'h0001_0000, 32'h0001_0000,  32'h0,          32'h0);
        add_vec("mulhu",     11, 32'h0001_0000, 32'h0001_0000,  32'h1,          32'h0);
        add_vec("mul_3x4",   10, 32'h3,         32'h4,          32'hC,          32'h0);
        add_vec("div_neg",   12, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFD,  32'h0);
        add_vec("rem_neg",   14, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF,  32'h0);
        add_vec("div_negb",  12, 32'h7,         32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h0);
        add_vec("rem_negb",  14, 32'h7,         32'hFFFF_FFFE,  32'h1,          32'h0);
        add_vec("divu_by0",  13, 32'h7,         32'h0,          32'hFFFF_FFFF,  32'h0);
        add_vec("remu_by0",  15, 32'h7,         32'h0,          32'h7,          32'h0);
        add_vec("div_ovf",   12, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'h0);
        add_vec("rem_ovf",   14, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,          32'h0);
        add_vec("divu_big",  13, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,          32'h0);
        add_vec("remu_big",  15, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'h0);
        add_vec("unknown",   20, 32'h1234_5678, 32'h9ABC_DEF0,  32'h0,          32'h0);
        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   MD_EN ? vecs[i].exp_on : vecs[i].exp_off);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 17));
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = y & 32'hFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, op), op, x, y, ref_alu(op, x, y));
        end

        // Back-to-back single-cycle ops at one result per clock
        out_ready = 1'b1;
        opcode = 5'd0; a = 32'hFFFF_FFFF; b = 32'h1; in_valid = 1'b1;
        step();
        check("b2b.first_valid", out_valid, 1);
        check("b2b.first_out", out, 32'h0);
        check("b2b.ready", in_ready, 1);
        opcode = 5'd7; a = 32'h8000_0000; b = 32'h24;
        step();
        in_valid = 1'b0;
        check("b2b.second_valid", out_valid, 1);
        check("b2b.second_out", out, 32'hF800_0000);
        step();
        out_ready = 1'b0;
        check("b2b.drained", out_valid, 0);

        // Backpressure: result held stable, then accept on release
        opcode = 5'd0; a = 32'd5; b = 32'd6; in_valid = 1'b1;
        step();
        opcode = 5'd1; a = 32'd9; b = 32'd4;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d.out", i), out, 32'd11);
            check($sformatf("hold%0d.valid", i), out_valid, 1);
            check($sformatf("hold%0d.in_ready", i), in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("release.in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("release.out", out, 32'd5);
        check("release.valid", out_valid, 1);
        step();
        out_ready = 1'b0;

        // Flush part-way through a division
        opcode = 5'd12; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("flush.busy_before", busy, ref_lat(12, 32'd100, 32'd7) > 1);
        flush = 1'b1;
        #1;
        check("flush.in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        check("flush.valid_after", out_valid, 0);
        check("flush.busy_after", busy, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) cnt++;
            step();
        end
        check("flush.no_result", cnt, 0);

        // Asynchronous reset in the middle of a multiply
        run_op("pre_rst_add", 0, 32'd5, 32'd6, 32'd11);
        opcode = 5'd10; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_mul.out", out, MD_EN ? 32'd11 : 32'd0);
        check("mid_mul.valid", out_valid, !MD_EN);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async.out", out, 0);
        check("rst_async.valid", out_valid, 0);
        check("rst_async.busy", busy, 0);
        step();
        rst = 1'b0;
        step();
        run_op("post_rst_sub", 1, 32'd10, 32'd3, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire
